// File: rtl/input_debouncer_pkg.sv
// Shared constants for the pad-input debouncer and the wrapper that consumes it.
// Defaults live here so the wrapper and the debouncer agree on sizes and reset state.
package input_debouncer_pkg;

    localparam int DEFAULT_WIDTH           = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int MIN_DEBOUNCE_CYCLES     = 1;
    localparam int MAX_DEBOUNCE_CYCLES     = 65535;

    // Every stable_out bit comes out of reset low; the wrapper replicates this per bit.
    localparam logic STABLE_RESET_BIT = 1'b0;

    // Counter width that can hold 0..cycles without wrapping.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    // Reports whether a requested debounce window is inside the supported range.
    function automatic bit debounce_cycles_legal(input int cycles);
        return (cycles >= MIN_DEBOUNCE_CYCLES) && (cycles <= MAX_DEBOUNCE_CYCLES);
    endfunction

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// One conditioned input bit: two-flop synchronizer, persistence counter and stable flop.
// Strobes are registered so nothing downstream sees a combinational path from the pad.
module debounce_bit
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // The synchronizer keeps tracking the pad even while evaluation is frozen,
    // so re-enabling never evaluates a stale level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing
    // samples; any return to the stable level restarts the window from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= STABLE_RESET_BIT;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!ena) begin
                cnt <= '0;
            end else if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                rise   <= sync2;
                fall   <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Front-end conditioning of the raw pad byte: per-bit synchronize and debounce,
// then present the stable byte with per-bit edge strobes and a combined change pulse.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    // Bits share nothing but clock, reset and enable, so each gets its own lane.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .ena    (ena),
            .raw    (raw_in[i]),
            .stable (stable_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    // Both strobes are flop outputs, so this pulse is glitch-free and lasts one cycle.
    assign changed = |(rise | fall);

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (WIDTH=8, DEBOUNCE_CYCLES=4) against a
// sample-history reference model: a level is accepted once the last N enabled samples all differ.
module tb_input_debouncer;

    localparam int W = 8;
    localparam int N = 4;
    localparam logic [31:0] RUN_MASK = (32'd1 << N) - 32'd1;

    logic         clk;
    logic         rst;
    logic         ena;
    logic [W-1:0] raw_in;
    logic [W-1:0] stable_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int total = 0;
    int bad   = 0;

    input_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .raw_in     (raw_in),
        .stable_out (stable_out),
        .rise       (rise),
        .fall       (fall),
        .changed    (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pad level seen two edges late, plus a per-bit history of
    // "sample differed from stable" flags over enabled edges.
    logic [W-1:0]  m_d1, m_d2;
    logic [31:0]   hist [W];
    logic [W-1:0]  exp_stable, exp_rise, exp_fall;

    always @(posedge clk or posedge rst) begin : model
        logic [31:0]  h;
        logic [W-1:0] s_n, r_n, f_n;
        if (rst) begin
            m_d1       <= '0;
            m_d2       <= '0;
            exp_stable <= '0;
            exp_rise   <= '0;
            exp_fall   <= '0;
            for (int i = 0; i < W; i++) hist[i] <= '0;
        end else begin
            s_n = exp_stable;
            r_n = '0;
            f_n = '0;
            for (int i = 0; i < W; i++) begin
                if (!ena) begin
                    h = '0;
                end else begin
                    h = {hist[i][30:0], (m_d2[i] != exp_stable[i])};
                    if ((h & RUN_MASK) == RUN_MASK) begin
                        s_n[i] = m_d2[i];
                        r_n[i] = m_d2[i];
                        f_n[i] = ~m_d2[i];
                        h      = '0;
                    end
                end
                hist[i] <= h;
            end
            m_d1       <= raw_in;
            m_d2       <= m_d1;
            exp_stable <= s_n;
            exp_rise   <= r_n;
            exp_fall   <= f_n;
        end
    end

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; raw_in = 8'hFF;
        repeat (3) @(negedge clk);
        total++;
        if ({stable_out, rise, fall, changed} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_hold got=%h exp=0", {stable_out, rise, fall, changed});
        end
        raw_in = '0;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ({stable_out, rise, fall, changed} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_release c=%0d got=%h exp=0", c, {stable_out, rise, fall, changed});
            end
        end
    endtask

    task automatic test_glitch();
        raw_in = 8'h01;
        for (int c = 0; c < 14; c++) begin
            if (c == 3) raw_in = 8'h00;
            @(negedge clk);
            total++;
            if ({stable_out, changed, rise, fall} !== {exp_stable, |(exp_rise | exp_fall), exp_rise, exp_fall}
                || stable_out !== 8'h00 || changed !== 1'b0) begin
                bad++;
                $display("[TB] FAIL glitch c=%0d got stable=%h chg=%b exp stable=00 chg=0", c, stable_out, changed);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses;
        int first_edge;
        pulses = 0;
        first_edge = 0;
        for (int c = 0; c < 20; c++) begin
            raw_in = ((c / 2) % 2 == 0) ? 8'h08 : 8'h00;
            @(negedge clk);
            if (changed) pulses++;
            total++;
            if ({stable_out, rise, fall} !== {exp_stable, exp_rise, exp_fall}) begin
                bad++;
                $display("[TB] FAIL bounce_model c=%0d got=%h exp=%h", c, {stable_out, rise, fall}, {exp_stable, exp_rise, exp_fall});
            end
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("[TB] FAIL bounce_pulses got=%0d exp=0", pulses);
        end
        raw_in = 8'h08;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (rise[3] && first_edge == 0) first_edge = e;
            if (changed) pulses++;
        end
        total++;
        if (first_edge != 6 || pulses != 1 || stable_out !== 8'h08) begin
            bad++;
            $display("[TB] FAIL bounce_accept got edge=%0d pulses=%0d stable=%h exp edge=6 pulses=1 stable=08",
                     first_edge, pulses, stable_out);
        end
        raw_in = 8'h00;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_basic();
        raw_in = 8'h5A;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            total++;
            if (e == 5 && (stable_out !== 8'h00 || changed !== 1'b0)) begin
                bad++;
                $display("[TB] FAIL basic_early got stable=%h chg=%b exp stable=00 chg=0", stable_out, changed);
            end else if (e == 6 && {stable_out, rise, fall, changed} !== {8'h5A, 8'h5A, 8'h00, 1'b1}) begin
                bad++;
                $display("[TB] FAIL basic_accept got=%h exp=%h", {stable_out, rise, fall, changed}, {8'h5A, 8'h5A, 8'h00, 1'b1});
            end else if (e == 7 && {stable_out, rise, fall, changed} !== {8'h5A, 8'h00, 8'h00, 1'b0}) begin
                bad++;
                $display("[TB] FAIL basic_oneshot got=%h exp=%h", {stable_out, rise, fall, changed}, {8'h5A, 8'h00, 8'h00, 1'b0});
            end else if ({stable_out, rise, fall} !== {exp_stable, exp_rise, exp_fall}) begin
                bad++;
                $display("[TB] FAIL basic_model e=%0d got=%h exp=%h", e, {stable_out, rise, fall}, {exp_stable, exp_rise, exp_fall});
            end
        end
    endtask

    task automatic test_swap();
        int pulses;
        pulses = 0;
        raw_in = 8'hA5;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (changed) pulses++;
            if (e == 6) begin
                total++;
                if ({stable_out, rise, fall, changed} !== {8'hA5, 8'hA5, 8'h5A, 1'b1}) begin
                    bad++;
                    $display("[TB] FAIL swap_accept got=%h exp=%h", {stable_out, rise, fall, changed}, {8'hA5, 8'hA5, 8'h5A, 1'b1});
                end
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("[TB] FAIL swap_pulses got=%0d exp=1", pulses);
        end
        raw_in = 8'h00;
        repeat (8) @(negedge clk);
        total++;
        if (stable_out !== 8'h00) begin
            bad++;
            $display("[TB] FAIL swap_return got=%h exp=00", stable_out);
        end
    endtask

    task automatic test_enable();
        ena = 1'b0;
        raw_in = 8'hFF;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++;
            if ({stable_out, rise, fall, changed} !== '0) begin
                bad++;
                $display("[TB] FAIL enable_frozen c=%0d got=%h exp=0", c, {stable_out, rise, fall, changed});
            end
        end
        ena = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            if (e == 3 || e == 4) begin
                total++;
                if (stable_out !== ((e == 4) ? 8'hFF : 8'h00) || rise !== ((e == 4) ? 8'hFF : 8'h00)) begin
                    bad++;
                    $display("[TB] FAIL enable_resume e=%0d got stable=%h rise=%h exp stable=rise=%h",
                             e, stable_out, rise, (e == 4) ? 8'hFF : 8'h00);
                end
            end
        end
        raw_in = 8'h00;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        raw_in = 8'h0F;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({stable_out, rise, fall, changed} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_async got=%h exp=0", {stable_out, rise, fall, changed});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            if (e == 5 || e == 6) begin
                total++;
                if (stable_out !== ((e == 6) ? 8'h0F : 8'h00)) begin
                    bad++;
                    $display("[TB] FAIL reset_relatch e=%0d got=%h exp=%h", e, stable_out, (e == 6) ? 8'h0F : 8'h00);
                end
            end
        end
        raw_in = 8'h00;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                raw_in = raw_in ^ (W'($urandom) & W'($urandom));
                hold = $urandom_range(1, 7);
            end
            hold--;
            ena = ($urandom_range(0, 15) != 0);
            @(negedge clk);
            total++;
            if ({stable_out, rise, fall, changed} !== {exp_stable, exp_rise, exp_fall, |(exp_rise | exp_fall)}) begin
                bad++;
                $display("[TB] FAIL random c=%0d got=%h exp=%h", c,
                         {stable_out, rise, fall, changed}, {exp_stable, exp_rise, exp_fall, |(exp_rise | exp_fall)});
            end
        end
        ena = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        raw_in = '0;
        test_reset();
        test_glitch();
        test_bounce();
        test_basic();
        test_swap();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
